risc_core_mc: RTL and testbench
===============================

# risc_core_mc

Parametrised multi-cycle successor to the non-pipelined 16-bit RISC core. It runs the same 16-bit fixed-format instruction set over a configurable data width. Instruction and data memories are reached through req/ack handshakes, so either memory may insert wait states. The block is the core top: an FSM, PC, IR, an 8-entry register file and the ALU in one module, sitting between the testbench/SoC memories.

## Interface
- `DATA_W`, 16: register/ALU/data-memory width; legal values 16 or 32.
- `IMEM_SIZE`, 32: number of instruction words; a PC value `>= IMEM_SIZE` is out of range.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output 16: word address of the fetch (current PC).
- `imem_ack` input 1: fetch complete; `imem_rdata` is valid in this cycle.
- `imem_rdata` input 16: instruction word.
- `dmem_req` output 1: data access request.
- `dmem_wr` output 1: 1 = store, 0 = load; meaningful only while `dmem_req` is high.
- `dmem_addr` output DATA_W: data word address.
- `dmem_wdata` output DATA_W: store data.
- `dmem_ack` input 1: access complete; `dmem_rdata` is valid in this cycle for a load.
- `dmem_rdata` input DATA_W: load data.
- `halt` output 1: core stopped; sticky until `rst`.
- `err` output 1: illegal-opcode trap taken; sticky until `rst`.

## Operation
- Instruction fields: `op=[15:12]`, `rd=[11:9]`, `rs=[8:6]`, `rt=[5:3]`, `imm6=[5:0]`, `imm12=[11:0]`. `sx(imm6)` is sign-extended to DATA_W.
- Register file: 8 registers of DATA_W bits. r0 always reads 0 and writes to it are discarded. All registers reset to 0.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: `rd = rs op rt`.
  - 6 ADDI: `rd = rs + sx(imm6)`.
  - 7 LD: `rd = mem[rs + sx(imm6)]`.
  - 8 ST: `mem[rs + sx(imm6)] = rd`.
  - 9 BLTZ: if `rs[DATA_W-1]`, then `pc = pc + 1 + sx(imm6)`.
  - 10 JMP: `pc = imm12`.
  - 15 HALT.
  - 11–14 are illegal (see Configuration).
- Arithmetic is modulo 2^DATA_W; there are no flags. PC arithmetic is 16-bit modulo 2^16.
- FSM states: FETCH, EXEC, MEM, HALTED. Reset enters FETCH with `pc = 0`.
  - FETCH → HALTED if `pc >= IMEM_SIZE`, with no request issued.
  - Otherwise FETCH holds `imem_req`; IR is loaded in the `imem_ack` cycle and the FSM moves to EXEC.
  - EXEC: ALU ops, branch and jump update rd/pc and return to FETCH. LD/ST go to MEM. HALT goes to HALTED.
  - MEM holds `dmem_req` until `dmem_ack`. For LD, rd is written with `dmem_rdata` in the ack cycle. Then `pc = pc + 1` and the FSM returns to FETCH.
  - HALTED: no requests; only `rst` exits.
- `dmem_addr`, `dmem_wdata` and `dmem_wr` are registered and held stable while `dmem_req` is high. `imem_addr` is held stable while `imem_req` is high.
- A branch or jump to a target `>= IMEM_SIZE` halts on the next FETCH. The same applies to sequential fall-through past `IMEM_SIZE-1`.

## Timing
- Reset values: `imem_req = 0`, `dmem_req = 0`, `dmem_wr = 0`, `imem_addr = 0`, `dmem_addr = 0`, `dmem_wdata = 0`, `halt = 0`, `err = 0`.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- Ack may arrive in the same cycle as req (zero wait). Each wait cycle adds one cycle.
- Req deasserts in the cycle after ack. No new request starts in that cycle, because the FSM is in EXEC.
- Zero-wait latencies: ALU/branch/jump/NOP take 2 cycles; LD/ST take 3 cycles; HALT asserts `halt` 2 cycles after the fetch of the HALT word.
- An ack received while req is low is ignored.
- Register writes land at the end of EXEC (ALU ops) or at the end of the ack cycle (LD). The next instruction sees the new value.
- `rst` mid-request drops req at that edge. Memories must tolerate an abandoned request. No register, IR or PC update from the interrupted instruction survives.

## Configuration
- Macro: `RISC_CORE_MC_TRAP_EN`.
- Defined: opcodes 11–14 set `err = 1` and `halt = 1` on the EXEC cycle, and the PC stays at the offending instruction.
- Undefined: opcodes 11–14 execute as NOP, and `err` is tied to 0.

## Test plan
- ALU, zero-wait, DATA_W=16:
  - Program: `ADDI r1,r0,5`; `ADDI r2,r0,-3`; `SUB r3,r1,r2`; `HALT`.
  - Expect r3 = 8, `halt` high 8 cycles after reset release, 4 fetches, no `dmem_req`.
- Load/store with wait states:
  - Program: `ST r1,r0,2`; `LD r4,r0,2`.
  - The dmem model delays ack by 3 cycles.
  - Expect `dmem_addr = 2`, `dmem_wdata = 5`, `dmem_wr = 1` held for 4 cycles; then r4 = 5. Each access takes 6 cycles.
- Branch and bounds:
  - `BLTZ r2,+2` with r2 = -3 skips two words.
  - `JMP 40` with IMEM_SIZE = 32 sets `halt` with no fetch at address 40.
  - Sequential fall-through from word 31 halts the same way.
- DATA_W=32 wrap:
  - `ADDI` on r1 = 0x7FFFFFFF with imm 1 gives 0x80000000.
  - A subsequent `BLTZ r1` is taken.
- Illegal opcode 0xB000:
  - With the macro: `err = 1`, `halt = 1`, `imem_addr` stuck at that word.
  - Without the macro: execution continues to the next word.
- Reset mid-MEM:
  - Assert `rst` while `dmem_req` is pending.
  - Next cycle: `dmem_req = 0`, all outputs at their reset values, refetch from address 0.

Source files
------------

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 16-bit-instruction RISC core with DATA_W-wide
// datapath. FSM (FETCH/EXEC/MEM/HALTED), PC, IR, 8-entry register file and
// ALU in one module. Instruction and data memories use req/ack handshakes.
// Optional feature macro: RISC_CORE_MC_TRAP_EN (opcodes 11-14 trap to
// err/halt when defined; they execute as NOP when undefined).
//
// Handshake: the core raises req and holds it, with address/write data/
// direction stable, until the memory returns ack in a cycle where req is
// high; the transfer completes on that cycle's rising edge and req drops in
// the following cycle. An ack seen while req is low is ignored.
module risc_core_mc #(
   parameter int DATA_W    = 16,
   parameter int IMEM_SIZE = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [15:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_wr,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halt,
   output logic              err,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_MEM    = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LD   = 4'd7;
   localparam logic [3:0] OP_ST   = 4'd8;
   localparam logic [3:0] OP_BLTZ = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd15;

   // 17 bits so an IMEM_SIZE of 65536 still compares correctly
   localparam logic [16:0] IMEM_LIM = 17'(IMEM_SIZE);

   state_t              r_state;
   logic [15:0]         r_pc;
   logic [15:0]         r_ir;
   logic [DATA_W-1:0]   r_regs [8];
   logic                r_dmem_req;
   logic                r_dmem_wr;
   logic [DATA_W-1:0]   r_dmem_addr;
   logic [DATA_W-1:0]   r_dmem_wdata;
   logic                r_halt;
`ifdef RISC_CORE_MC_TRAP_EN
   logic                r_err;
`endif

   logic [3:0]          w_op;
   logic [2:0]          w_rd;
   logic [2:0]          w_rs;
   logic [2:0]          w_rt;
   logic [11:0]         w_imm12;
   logic [DATA_W-1:0]   w_sx_imm;
   logic [15:0]         w_sx_imm16;
   logic [DATA_W-1:0]   w_rs_val;
   logic [DATA_W-1:0]   w_rt_val;
   logic [DATA_W-1:0]   w_rd_val;
   logic [DATA_W-1:0]   w_alu;
   logic [15:0]         w_pc_inc;
   logic                w_pc_ok;

   assign w_op       = r_ir[15:12];
   assign w_rd       = r_ir[11:9];
   assign w_rs       = r_ir[8:6];
   assign w_rt       = r_ir[5:3];
   assign w_imm12    = r_ir[11:0];
   assign w_sx_imm   = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
   assign w_sx_imm16 = {{10{r_ir[5]}}, r_ir[5:0]};

   // r0 reads as zero regardless of array contents
   assign w_rs_val = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
   assign w_rt_val = (w_rt == 3'd0) ? '0 : r_regs[w_rt];
   assign w_rd_val = (w_rd == 3'd0) ? '0 : r_regs[w_rd];

   assign w_pc_inc = r_pc + 16'd1;
   assign w_pc_ok  = ({1'b0, r_pc} < IMEM_LIM);

   // Fetch request is decoded from state so it is up in the first cycle
   // after reset release; reset forces it low immediately.
   assign imem_req    = (r_state == S_FETCH) && w_pc_ok && !rst;
   assign imem_addr   = r_pc;
   assign dmem_req    = r_dmem_req;
   assign dmem_wr     = r_dmem_wr;
   assign dmem_addr   = r_dmem_addr;
   assign dmem_wdata  = r_dmem_wdata;
   assign halt        = r_halt;
   assign o_dbg_state = r_state;
`ifdef RISC_CORE_MC_TRAP_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // ALU result; also forms the effective address for LD/ST
   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:                 w_alu = w_rs_val + w_rt_val;
         OP_SUB:                 w_alu = w_rs_val - w_rt_val;
         OP_AND:                 w_alu = w_rs_val & w_rt_val;
         OP_OR:                  w_alu = w_rs_val | w_rt_val;
         OP_XOR:                 w_alu = w_rs_val ^ w_rt_val;
         OP_ADDI, OP_LD, OP_ST:  w_alu = w_rs_val + w_sx_imm;
         default:                w_alu = '0;
      endcase
   end

   // Core FSM: sequencing, PC/IR, register file and data-memory request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_pc         <= 16'd0;
         r_ir         <= 16'd0;
         r_dmem_req   <= 1'b0;
         r_dmem_wr    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_halt       <= 1'b0;
`ifdef RISC_CORE_MC_TRAP_EN
         r_err        <= 1'b0;
`endif
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!w_pc_ok) begin
                  r_halt  <= 1'b1;
                  r_state <= S_HALTED;
               end else if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (w_op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                     if (w_rd != 3'd0) r_regs[w_rd] <= w_alu;
                     r_pc    <= w_pc_inc;
                     r_state <= S_FETCH;
                  end
                  OP_LD, OP_ST: begin
                     r_dmem_req  <= 1'b1;
                     r_dmem_addr <= w_alu;
                     r_dmem_wr   <= (w_op == OP_ST);
                     if (w_op == OP_ST) r_dmem_wdata <= w_rd_val;
                     r_state     <= S_MEM;
                  end
                  OP_BLTZ: begin
                     r_pc    <= w_rs_val[DATA_W-1] ? (w_pc_inc + w_sx_imm16) : w_pc_inc;
                     r_state <= S_FETCH;
                  end
                  OP_JMP: begin
                     r_pc    <= {4'd0, w_imm12};
                     r_state <= S_FETCH;
                  end
                  OP_HALT: begin
                     r_halt  <= 1'b1;
                     r_state <= S_HALTED;
                  end
`ifdef RISC_CORE_MC_TRAP_EN
                  4'd11, 4'd12, 4'd13, 4'd14: begin
                     // PC stays on the offending word for post-mortem
                     r_err   <= 1'b1;
                     r_halt  <= 1'b1;
                     r_state <= S_HALTED;
                  end
`endif
                  default: begin
                     r_pc    <= w_pc_inc;
                     r_state <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ack && r_dmem_req) begin
                  if (!r_dmem_wr && (w_rd != 3'd0)) r_regs[w_rd] <= dmem_rdata;
                  r_dmem_req <= 1'b0;
                  r_dmem_wr  <= 1'b0;
                  r_pc       <= w_pc_inc;
                  r_state    <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc_core_mc.sv
// Bench for risc_core_mc: 16-bit instance with wait-state data memory and a
// 32-bit instance with zero-wait memories.
module tb_risc_core_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A: DATA_W=16, IMEM_SIZE=32 ----------------
   logic        rst_a = 1'b1;
   logic        imem_req_a, imem_ack_a;
   logic [15:0] imem_addr_a, imem_rdata_a;
   logic        dmem_req_a, dmem_wr_a, dmem_ack_a;
   logic [15:0] dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
   logic        halt_a, err_a;
   logic [1:0]  dbg_a;

   logic [15:0] imem_a [64];
   logic [15:0] dmem_a [16];
   int          dmem_wait_a = 0;
   int          dwait_cnt_a;
   int          fetch_cnt_a;
   logic        oob_a;
   logic        dreq_seen_a;
   logic [15:0] st_addr_q [$];
   logic [15:0] st_data_q [$];

   risc_core_mc #(.DATA_W(16), .IMEM_SIZE(32)) dut_a (
      .clk(clk), .rst(rst_a),
      .imem_req(imem_req_a), .imem_addr(imem_addr_a),
      .imem_ack(imem_ack_a), .imem_rdata(imem_rdata_a),
      .dmem_req(dmem_req_a), .dmem_wr(dmem_wr_a),
      .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
      .dmem_ack(dmem_ack_a), .dmem_rdata(dmem_rdata_a),
      .halt(halt_a), .err(err_a), .o_dbg_state(dbg_a)
   );

   assign imem_ack_a   = imem_req_a;
   assign imem_rdata_a = imem_a[imem_addr_a[5:0]];
   assign dmem_ack_a   = dmem_req_a && (dwait_cnt_a == dmem_wait_a);
   assign dmem_rdata_a = dmem_a[dmem_addr_a[3:0]];

   always @(posedge clk) begin
      if (rst_a) begin
         dwait_cnt_a <= 0;
         fetch_cnt_a <= 0;
         oob_a       <= 1'b0;
         dreq_seen_a <= 1'b0;
         st_addr_q.delete();
         st_data_q.delete();
         for (int i = 0; i < 16; i++) dmem_a[i] <= 16'h0;
      end else begin
         if (!dmem_req_a || dmem_ack_a) dwait_cnt_a <= 0;
         else dwait_cnt_a <= dwait_cnt_a + 1;
         if (imem_req_a && imem_ack_a) begin
            fetch_cnt_a <= fetch_cnt_a + 1;
            if (imem_addr_a >= 16'd32) oob_a <= 1'b1;
         end
         if (dmem_req_a) dreq_seen_a <= 1'b1;
         if (dmem_req_a && dmem_ack_a && dmem_wr_a) begin
            dmem_a[dmem_addr_a[3:0]] <= dmem_wdata_a;
            st_addr_q.push_back(dmem_addr_a);
            st_data_q.push_back(dmem_wdata_a);
         end
      end
   end

   // ---------------- instance B: DATA_W=32, IMEM_SIZE=32 ----------------
   logic        rst_b = 1'b1;
   logic        imem_req_b, imem_ack_b;
   logic [15:0] imem_addr_b, imem_rdata_b;
   logic        dmem_req_b, dmem_wr_b, dmem_ack_b;
   logic [31:0] dmem_addr_b, dmem_wdata_b, dmem_rdata_b;
   logic        halt_b, err_b;
   logic [1:0]  dbg_b;

   logic [15:0] imem_b [64];
   logic [31:0] dmem_b [16];
   logic [31:0] stb_addr_q [$];
   logic [31:0] stb_data_q [$];

   risc_core_mc #(.DATA_W(32), .IMEM_SIZE(32)) dut_b (
      .clk(clk), .rst(rst_b),
      .imem_req(imem_req_b), .imem_addr(imem_addr_b),
      .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
      .dmem_req(dmem_req_b), .dmem_wr(dmem_wr_b),
      .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
      .dmem_ack(dmem_ack_b), .dmem_rdata(dmem_rdata_b),
      .halt(halt_b), .err(err_b), .o_dbg_state(dbg_b)
   );

   assign imem_ack_b   = imem_req_b;
   assign imem_rdata_b = imem_b[imem_addr_b[5:0]];
   assign dmem_ack_b   = dmem_req_b;
   assign dmem_rdata_b = dmem_b[dmem_addr_b[3:0]];

   always @(posedge clk) begin
      if (rst_b) begin
         stb_addr_q.delete();
         stb_data_q.delete();
         for (int i = 0; i < 16; i++) dmem_b[i] <= 32'h0;
         dmem_b[0] <= 32'h7FFF_FFFF;
      end else if (dmem_req_b && dmem_ack_b && dmem_wr_b) begin
         dmem_b[dmem_addr_b[3:0]] <= dmem_wdata_b;
         stb_addr_q.push_back(dmem_addr_b);
         stb_data_q.push_back(dmem_wdata_b);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [5:0] low);
      return {op, rd, rs, low};
   endfunction

   function automatic logic [63:0] st_addr(input int i);
      return (i < st_addr_q.size()) ? 64'(st_addr_q[i]) : 64'hDEAD_0000;
   endfunction

   function automatic logic [63:0] st_data(input int i);
      return (i < st_data_q.size()) ? 64'(st_data_q[i]) : 64'hDEAD_0000;
   endfunction

   task automatic clear_imem_a();
      for (int i = 0; i < 64; i++) imem_a[i] = 16'h0000;
   endtask

   // Hold reset two cycles, then release mid-cycle (at a falling edge)
   task automatic reset_a();
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic wait_halt_a(input string nm, input int budget);
      int n;
      n = 0;
      while (!halt_a && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_halt"}, 64'(halt_a), 64'd1);
   endtask

   typedef struct {
      string      name;
      logic [3:0] op;
      int         a;
      int         b;
      logic [15:0] exp;
   } alu_vec_t;

   alu_vec_t vecs [8];

   initial begin
      int n;

      vecs[0] = '{"add",     4'd1,   5,   7, 16'h000C};
      vecs[1] = '{"sub_pos", 4'd2,   5,  -3, 16'h0008};
      vecs[2] = '{"sub_neg", 4'd2,   3,  10, 16'hFFF9};
      vecs[3] = '{"and",     4'd3,  -1,  21, 16'h0015};
      vecs[4] = '{"or",      4'd4,  10,   5, 16'h000F};
      vecs[5] = '{"xor",     4'd5,  -1,   5, 16'hFFFA};
      vecs[6] = '{"add_min", 4'd1, -32, -32, 16'hFFC0};
      vecs[7] = '{"xor_zero",4'd5,  31,  31, 16'h0000};

      // ---- T1: reset values, ALU program timing ----
      clear_imem_a();
      imem_a[0] = 16'h6205;   // ADDI r1,r0,5
      imem_a[1] = 16'h643D;   // ADDI r2,r0,-3
      imem_a[2] = 16'h2650;   // SUB  r3,r1,r2
      imem_a[3] = 16'hF000;   // HALT
      dmem_wait_a = 0;
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_imem_req",   64'(imem_req_a),   64'd0);
      check("rst_dmem_req",   64'(dmem_req_a),   64'd0);
      check("rst_dmem_wr",    64'(dmem_wr_a),    64'd0);
      check("rst_imem_addr",  64'(imem_addr_a),  64'd0);
      check("rst_dmem_addr",  64'(dmem_addr_a),  64'd0);
      check("rst_dmem_wdata", 64'(dmem_wdata_a), 64'd0);
      check("rst_halt",       64'(halt_a),       64'd0);
      check("rst_err",        64'(err_a),        64'd0);
      rst_a = 1'b0;
      #1;
      check("t1_first_req", 64'(imem_req_a), 64'd1);
      repeat (7) @(negedge clk);
      check("t1_halt_at7", 64'(halt_a), 64'd0);
      @(negedge clk);
      check("t1_halt_at8",  64'(halt_a),          64'd1);
      check("t1_fetches",   64'(fetch_cnt_a),     64'd4);
      check("t1_no_dreq",   64'(dreq_seen_a),     64'd0);
      check("t1_r3",        64'(dut_a.r_regs[3]), 64'd8);
      repeat (2) @(negedge clk);
      check("t1_halt_sticky", 64'(halt_a),     64'd1);
      check("t1_no_req",      64'(imem_req_a), 64'd0);

      // ---- T2: table-driven ALU vectors, result observed via ST ----
      for (int v = 0; v < 8; v++) begin
         clear_imem_a();
         imem_a[0] = enc(4'd6, 3'd1, 3'd0, 6'(vecs[v].a));
         imem_a[1] = enc(4'd6, 3'd2, 3'd0, 6'(vecs[v].b));
         imem_a[2] = enc(vecs[v].op, 3'd3, 3'd1, {3'd2, 3'd0});
         imem_a[3] = 16'h8601;  // ST r3,r0,1
         imem_a[4] = 16'hF000;
         reset_a();
         wait_halt_a(vecs[v].name, 200);
         check({vecs[v].name, "_nst"},  64'(st_data_q.size()), 64'd1);
         check({vecs[v].name, "_addr"}, st_addr(0), 64'd1);
         check({vecs[v].name, "_data"}, st_data(0), 64'(vecs[v].exp));
      end

      // ---- T3: store then load with 3 wait states ----
      clear_imem_a();
      imem_a[0] = 16'h6205;   // ADDI r1,r0,5
      imem_a[1] = 16'h8202;   // ST r1,r0,2
      imem_a[2] = 16'h7802;   // LD r4,r0,2
      imem_a[3] = 16'h8803;   // ST r4,r0,3
      imem_a[4] = 16'hF000;
      dmem_wait_a = 3;
      reset_a();
      n = 0;
      while (!dmem_req_a && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("ldst_req_cycle", 64'(n), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("ldst_hold%0d_req", k),   64'(dmem_req_a),   64'd1);
         check($sformatf("ldst_hold%0d_addr", k),  64'(dmem_addr_a),  64'd2);
         check($sformatf("ldst_hold%0d_wdata", k), 64'(dmem_wdata_a), 64'd5);
         check($sformatf("ldst_hold%0d_wr", k),    64'(dmem_wr_a),    64'd1);
      end
      @(negedge clk);
      check("ldst_req_drop", 64'(dmem_req_a), 64'd0);
      wait_halt_a("ldst", 200);
      check("ldst_nst",   64'(st_data_q.size()), 64'd2);
      check("ldst_a0",    st_addr(0), 64'd2);
      check("ldst_d0",    st_data(0), 64'd5);
      check("ldst_a1",    st_addr(1), 64'd3);
      check("ldst_d1",    st_data(1), 64'd5);
      check("ldst_r4",    64'(dut_a.r_regs[4]), 64'd5);
      dmem_wait_a = 0;

      // ---- T4: BLTZ taken/not taken, JMP out of range ----
      clear_imem_a();
      imem_a[0] = 16'h643D;   // ADDI r2,r0,-3
      imem_a[1] = 16'h9082;   // BLTZ r2,+2 -> 4
      imem_a[2] = 16'h8405;   // ST r2,r0,5 (skipped)
      imem_a[3] = 16'h8406;   // ST r2,r0,6 (skipped)
      imem_a[4] = 16'h6A09;   // ADDI r5,r0,9
      imem_a[5] = 16'h9143;   // BLTZ r5,+3 (not taken)
      imem_a[6] = 16'h8A07;   // ST r5,r0,7
      imem_a[7] = 16'hA028;   // JMP 40
      reset_a();
      wait_halt_a("br", 200);
      check("br_nst",     64'(st_data_q.size()), 64'd1);
      check("br_addr",    st_addr(0), 64'd7);
      check("br_data",    st_data(0), 64'd9);
      check("br_fetches", 64'(fetch_cnt_a), 64'd6);
      check("br_no_oob",  64'(oob_a), 64'd0);
      check("br_pc",      64'(imem_addr_a), 64'd40);
      check("br_no_req",  64'(imem_req_a), 64'd0);

      // ---- T5: sequential fall-through past the last word ----
      clear_imem_a();
      imem_a[0]  = 16'hA01E;  // JMP 30
      imem_a[30] = 16'h6204;  // ADDI r1,r0,4
      imem_a[31] = 16'h820C;  // ST r1,r0,12
      reset_a();
      wait_halt_a("ft", 200);
      check("ft_nst",     64'(st_data_q.size()), 64'd1);
      check("ft_addr",    st_addr(0), 64'd12);
      check("ft_data",    st_data(0), 64'd4);
      check("ft_fetches", 64'(fetch_cnt_a), 64'd3);
      check("ft_no_oob",  64'(oob_a), 64'd0);
      check("ft_pc",      64'(imem_addr_a), 64'd32);

      // ---- T6: illegal opcode 0xB000 ----
      clear_imem_a();
      imem_a[0] = 16'h6201;   // ADDI r1,r0,1
      imem_a[1] = 16'hB000;
      imem_a[2] = 16'h8204;   // ST r1,r0,4
      imem_a[3] = 16'hF000;
      reset_a();
      wait_halt_a("ill", 200);
`ifdef RISC_CORE_MC_TRAP_EN
      check("ill_err",  64'(err_a), 64'd1);
      check("ill_pc",   64'(imem_addr_a), 64'd1);
      check("ill_nst",  64'(st_data_q.size()), 64'd0);
`else
      check("ill_err",  64'(err_a), 64'd0);
      check("ill_nst",  64'(st_data_q.size()), 64'd1);
      check("ill_addr", st_addr(0), 64'd4);
      check("ill_data", st_data(0), 64'd1);
`endif

      // ---- T7: reset while a store is pending ----
      clear_imem_a();
      imem_a[0] = 16'h6205;   // ADDI r1,r0,5
      imem_a[1] = 16'h8202;   // ST r1,r0,2
      imem_a[2] = 16'hF000;
      dmem_wait_a = 10;
      reset_a();
      n = 0;
      while (!dmem_req_a && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("rm_req_seen", 64'(dmem_req_a), 64'd1);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      check("rm_dmem_req",   64'(dmem_req_a),   64'd0);
      check("rm_dmem_wr",    64'(dmem_wr_a),    64'd0);
      check("rm_dmem_addr",  64'(dmem_addr_a),  64'd0);
      check("rm_dmem_wdata", 64'(dmem_wdata_a), 64'd0);
      check("rm_imem_addr",  64'(imem_addr_a),  64'd0);
      check("rm_imem_req",   64'(imem_req_a),   64'd0);
      check("rm_halt",       64'(halt_a),       64'd0);
      check("rm_nst",        64'(st_data_q.size()), 64'd0);
      dmem_wait_a = 0;
      rst_a = 1'b0;
      #1;
      check("rm_refetch_req",  64'(imem_req_a),  64'd1);
      check("rm_refetch_addr", 64'(imem_addr_a), 64'd0);
      wait_halt_a("rm", 200);
      check("rm_nst_after", 64'(st_data_q.size()), 64'd1);
      check("rm_addr",      st_addr(0), 64'd2);
      check("rm_data",      st_data(0), 64'd5);

      // ---- T8: DATA_W=32 wrap into the sign bit, then BLTZ taken ----
      for (int i = 0; i < 64; i++) imem_b[i] = 16'h0000;
      imem_b[0] = 16'h7200;   // LD r1,r0,0 (0x7FFFFFFF)
      imem_b[1] = 16'h6241;   // ADDI r1,r1,1
      imem_b[2] = 16'h8201;   // ST r1,r0,1
      imem_b[3] = 16'h9041;   // BLTZ r1,+1 -> 5
      imem_b[4] = 16'h8002;   // ST r0,r0,2 (skipped)
      imem_b[5] = 16'h8203;   // ST r1,r0,3
      imem_b[6] = 16'hF000;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      n = 0;
      while (!halt_b && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("w32_halt", 64'(halt_b), 64'd1);
      check("w32_err",  64'(err_b),  64'd0);
      check("w32_nst",  64'(stb_data_q.size()), 64'd2);
      check("w32_a0",   (stb_addr_q.size() > 0) ? 64'(stb_addr_q[0]) : 64'hDEAD_0000, 64'd1);
      check("w32_d0",   (stb_data_q.size() > 0) ? 64'(stb_data_q[0]) : 64'hDEAD_0000, 64'h8000_0000);
      check("w32_a1",   (stb_addr_q.size() > 1) ? 64'(stb_addr_q[1]) : 64'hDEAD_0000, 64'd3);
      check("w32_d1",   (stb_data_q.size() > 1) ? 64'(stb_data_q[1]) : 64'hDEAD_0000, 64'h8000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
